q_table_update: RTL and testbench

Q-table owner and writer for the maze Q-learning datapath. Holds the 37×4 table of 32-bit unsigned Q-values, and exposes it as a flat array to the action-selection logic that reads it. On each start request it applies one Q-learning update: it scans the next state's four entries for the maximum, computes the shift-scaled update, and writes the new value back. It sits beside the action selector and is driven by the maze controller after each completed move.

---
 rtl/q_table_update.sv | 155 +++++++++++++++
 tb/tb_q_table_update.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/q_table_update.sv
// Q-table owner and single-writer update engine for the maze Q-learning datapath.
// Each accepted request scans Q[s'][*] for its unsigned maximum, forms the
// shift-scaled temporal-difference update and writes the clamped result to Q[s][a].
module q_table_update #(
    parameter int unsigned N_STATES    = 37,
    parameter int unsigned N_ACTIONS   = 4,
    parameter int unsigned W           = 32,
    parameter int unsigned ALPHA_SHIFT = 2,
    parameter int unsigned GAMMA_SHIFT = 3
) (
    input  logic                                     clk_i,
    input  logic                                     rst_ni,
    input  logic                                     start_i,
    input  logic [5:0]                               state_i,
    input  logic [3:0]                               action_i,
    input  logic [5:0]                               next_state_i,
    input  logic [15:0]                              reward_i,
    output logic                                     busy_o,
    output logic                                     done_o,
    output logic                                     err_o,
    output logic [W-1:0]                             q_new_o,
    output logic [15:0]                              update_count_o,
    output logic [N_STATES-1:0][N_ACTIONS-1:0][W-1:0] q_table_o
);

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StCalc,
        StWrite,
        StReject
    } state_e;

    state_e                                  fsm_q;
    logic [N_STATES-1:0][N_ACTIONS-1:0][W-1:0] q_table_q;
    logic [5:0]                              s_q;
    logic [1:0]                              a_q;
    logic [5:0]                              ns_q;
    logic [15:0]                             r_q;
    logic [1:0]                              idx_q;
    logic [W-1:0]                            max_q;
    logic [W-1:0]                            q_calc_q;
    logic [W-1:0]                            q_new_q;
    logic [15:0]                             count_q;
    logic                                    busy_q;
    logic                                    done_q;
    logic                                    err_q;

    logic                                    req_bad;
    logic [W-1:0]                            scan_val;
    logic [W-1:0]                            q_sa;
    logic [W-1:0]                            gq;
    logic signed [W+1:0]                     target;
    logic signed [W+1:0]                     delta;
    logic signed [W+1:0]                     step;
    logic signed [W+2:0]                     sum;
    logic [W-1:0]                            q_calc_d;

    // Request validation and the update arithmetic feeding the CALC register.
    always_comb begin
        req_bad  = (32'(state_i) >= N_STATES) || (32'(next_state_i) >= N_STATES) ||
                   (action_i > 4'd3);
        scan_val = q_table_q[ns_q][idx_q];
        q_sa     = q_table_q[s_q][a_q];
        gq       = max_q - (max_q >> GAMMA_SHIFT);
        target   = $signed({2'b00, gq}) + $signed({{(W + 2 - 16){r_q[15]}}, r_q});
        delta    = target - $signed({2'b00, q_sa});
        step     = delta >>> ALPHA_SHIFT;
        sum      = $signed({3'b000, q_sa}) + $signed({step[W+1], step});
        // Saturate the 35-bit signed sum into the unsigned W-bit range.
        if (sum[W+2]) begin
            q_calc_d = '0;
        end else if (sum[W+1:W] != 2'b00) begin
            q_calc_d = '1;
        end else begin
            q_calc_d = sum[W-1:0];
        end
    end

    // Control FSM, table storage and all registered outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fsm_q     <= StIdle;
            q_table_q <= '0;
            s_q       <= '0;
            a_q       <= '0;
            ns_q      <= '0;
            r_q       <= '0;
            idx_q     <= '0;
            max_q     <= '0;
            q_calc_q  <= '0;
            q_new_q   <= '0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            unique case (fsm_q)
                StIdle: begin
                    if (start_i) begin
                        s_q    <= state_i;
                        a_q    <= action_i[1:0];
                        ns_q   <= next_state_i;
                        r_q    <= reward_i;
                        idx_q  <= '0;
                        busy_q <= 1'b1;
                        fsm_q  <= req_bad ? StReject : StScan;
                    end
                end
                StScan: begin
                    // Strictly-greater replace keeps the lowest index on ties.
                    if (idx_q == 2'd0 || scan_val > max_q) begin
                        max_q <= scan_val;
                    end
                    idx_q <= idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        fsm_q <= StCalc;
                    end
                end
                StCalc: begin
                    q_calc_q <= q_calc_d;
                    fsm_q    <= StWrite;
                end
                StWrite: begin
                    q_table_q[s_q][a_q] <= q_calc_q;
                    q_new_q             <= q_calc_q;
                    count_q             <= count_q + 16'd1;
                    done_q              <= 1'b1;
                    busy_q              <= 1'b0;
                    fsm_q               <= StIdle;
                end
                StReject: begin
                    done_q <= 1'b1;
                    err_q  <= 1'b1;
                    busy_q <= 1'b0;
                    fsm_q  <= StIdle;
                end
                default: begin
                    busy_q <= 1'b0;
                    fsm_q  <= StIdle;
                end
            endcase
        end
    end

    assign busy_o         = busy_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign q_new_o        = q_new_q;
    assign update_count_o = count_q;
    assign q_table_o      = q_table_q;

endmodule

// File: tb/tb_q_table_update.sv
// Directed bench for q_table_update with a reference model and scoreboard queue.
module tb_q_table_update;

    localparam int NS = 37;
    localparam int NA = 4;
    localparam int W  = 32;

    logic                             clk = 1'b0;
    logic                             rst_n = 1'b0;
    logic                             start = 1'b0;
    logic [5:0]                       st = '0;
    logic [3:0]                       act = '0;
    logic [5:0]                       nst = '0;
    logic [15:0]                      rew = '0;
    logic                             busy;
    logic                             done;
    logic                             err;
    logic [W-1:0]                     q_new;
    logic [15:0]                      cnt;
    logic [NS-1:0][NA-1:0][W-1:0]     qt;

    int checks = 0;
    int errors = 0;

    longint mq[NS][NA];
    longint mqnew;
    int     mcount;

    typedef struct {
        bit     err;
        longint q;
        int     cnt;
        int     lat;
    } exp_t;
    exp_t sb[$];

    q_table_update dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
        .state_i        (st),
        .action_i       (act),
        .next_state_i   (nst),
        .reward_i       (rew),
        .busy_o         (busy),
        .done_o         (done),
        .err_o          (err),
        .q_new_o        (q_new),
        .update_count_o (cnt),
        .q_table_o      (qt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic chk_table(input string tag);
        logic [NS-1:0][NA-1:0][W-1:0] et;
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < NA; j++)
                et[i][j] = mq[i][j][W-1:0];
        checks++;
        assert (qt === et)
        else begin
            errors++;
            $error("FAIL %s observed table differs from expected table", tag);
        end
    endtask

    function automatic longint model_upd(int s, int a, int ns, int r);
        longint maxq, gq, d, stp, sum;
        maxq = mq[ns][0];
        for (int i = 1; i < NA; i++)
            if (mq[ns][i] > maxq) maxq = mq[ns][i];
        gq  = maxq - (maxq >>> 3);
        d   = gq + longint'(r) - mq[s][a];
        stp = d >>> 2;
        sum = mq[s][a] + stp;
        if (sum < 0) sum = 0;
        if (sum > 64'hFFFF_FFFF) sum = 64'hFFFF_FFFF;
        return sum;
    endfunction

    // Issue one request, optionally re-pulsing start during SCAN, and score the result.
    task automatic req(input string tag, input int s, input int a, input int ns, input int r,
                       input bit repulse);
        exp_t e;
        exp_t g;
        int   n;
        bit   bad;
        bad = (s >= NS) || (ns >= NS) || (a > 3);
        e.err = bad;
        if (bad) begin
            e.q   = mqnew;
            e.cnt = mcount;
            e.lat = 1;
        end else begin
            e.q   = model_upd(s, a, ns, r);
            e.cnt = (mcount + 1) % 65536;
            e.lat = 6;
        end
        sb.push_back(e);
        @(negedge clk);
        st    = s[5:0];
        act   = a[3:0];
        nst   = ns[5:0];
        rew   = r[15:0];
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        n = 0;
        chk({tag, "_busy_e0"}, busy, 1);
        if (repulse) begin
            repeat (2) begin
                @(posedge clk);
                #1 n++;
            end
            start = 1'b1;
            @(posedge clk);
            #1 n++;
            start = 1'b0;
        end
        while (done !== 1'b1 && n < 20) begin
            @(posedge clk);
            #1 n++;
        end
        g = sb.pop_front();
        if (!g.err) begin
            mq[s][a] = g.q;
            mqnew    = g.q;
            mcount   = g.cnt;
        end
        chk({tag, "_done"}, done, 1);
        chk({tag, "_lat"}, n, g.lat);
        chk({tag, "_err"}, err, g.err);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_qnew"}, q_new, g.q);
        chk({tag, "_count"}, cnt, g.cnt);
        chk_table({tag, "_table"});
        if (repulse) begin
            n = 0;
            repeat (12) begin
                @(posedge clk);
                #1 if (done === 1'b1) n++;
            end
            chk({tag, "_extra_done"}, n, 0);
            chk({tag, "_count_after"}, cnt, mcount);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NS; i++)
            for (int j = 0; j < NA; j++)
                mq[i][j] = 0;
        mqnew  = 0;
        mcount = 0;
    endtask

    initial begin
        int nd;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_qnew", q_new, 0);
        chk("rst_count", cnt, 0);
        chk_table("rst_table");
        @(negedge clk) rst_n = 1'b1;

        req("t1", 1, 1, 2, 100, 1'b0);
        chk("t1_q11", qt[1][1], 25);

        req("t2a", 2, 3, 5, 800, 1'b0);
        chk("t2a_q23", qt[2][3], 200);
        req("t2b", 1, 1, 2, 0, 1'b0);
        chk("t2b_q11", qt[1][1], 62);

        req("t3", 3, 0, 3, -1000, 1'b0);
        chk("t3_q30", qt[3][0], 0);

        req("rej_a", 1, 4, 2, 5, 1'b0);
        req("rej_ns", 1, 1, 37, 5, 1'b0);
        req("rej_s", 40, 1, 2, 5, 1'b0);

        req("t5", 4, 2, 1, 50, 1'b1);
        chk("t5_q42", qt[4][2], 26);

        // Reset asserted in the middle of SCAN aborts the pending write.
        @(negedge clk);
        st    = 6'd6;
        act   = 4'd0;
        nst   = 6'd1;
        rew   = 16'd500;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        model_reset();
        #2;
        chk("mrst_busy", busy, 0);
        chk("mrst_done", done, 0);
        chk("mrst_count", cnt, 0);
        chk("mrst_qnew", q_new, 0);
        chk_table("mrst_table");
        @(negedge clk) rst_n = 1'b1;
        nd = 0;
        repeat (10) begin
            @(posedge clk);
            #1 if (done === 1'b1) nd++;
        end
        chk("mrst_no_done", nd, 0);

        req("t6", 1, 1, 2, 100, 1'b0);
        chk("t6_q11", qt[1][1], 25);
        chk("t6_count", cnt, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
